uart_mmio: RTL and testbench

//  Memory-mapped UART peripheral on the CPU data bus, in parallel with DataMem, driven by the EX/MEM-stage

---
 rtl/uart_mmio.sv | 123 ++++++++++++
 tb/tb_uart_mmio.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: bus-mapped UART (TXD at BASE_ADDR, RXD +4, CON +8); ports clk/reset, MemRd/MemWr/Addr/WriteData/ReadData bus, rx/tx serial, irq on pending rx byte
module uart_mmio #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic sel_txd, sel_rxd, sel_con, wr_txd, wr_con, rd_rxd, unused_wd;
  assign sel_txd = Addr == BASE_ADDR;
  assign sel_rxd = Addr == BASE_ADDR + 32'd4;
  assign sel_con = Addr == BASE_ADDR + 32'd8;
  assign wr_txd = MemWr & sel_txd;
  assign wr_con = MemWr & sel_con;
  assign rd_rxd = MemRd & sel_rxd;
  assign unused_wd = ^WriteData[31:8];
  state_t ts, ts_n;
  logic [W-1:0] tcnt;
  logic [2:0] tbit;
  logic [7:0] tsh, tsh_n;
  logic tend, accept, tx_n, tx_busy;
  assign tend = tcnt == LAST;
  assign accept = wr_txd & (ts == IDLE);
  always_ff @(posedge clk)
    if (reset) ts <= IDLE;
    else ts <= ts_n;
  always_comb begin
    ts_n = ts;
    case (ts)
      IDLE:    ts_n = accept ? START : IDLE;
      START:   ts_n = tend ? DATA : START;
      DATA:    ts_n = (tend && tbit == 3'd7) ? STOP : DATA;
      default: ts_n = tend ? IDLE : STOP;
    endcase
  end
  // tx is registered from next-state values so the line never glitches on state decode
  always_comb begin
    tsh_n = accept ? WriteData[7:0] : (ts == DATA && tend) ? {1'b0, tsh[7:1]} : tsh;
    tx_n = ts_n == START ? 1'b0 : ts_n == DATA ? tsh_n[0] : 1'b1;
    tx_busy = ts != IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      tcnt <= '0;
      tbit <= '0;
      tsh <= '0;
      tx <= 1'b1;
    end else begin
      tcnt <= (ts == IDLE || tend) ? '0 : tcnt + 1'b1;
      tbit <= ts != DATA ? 3'd0 : tend ? tbit + 1'b1 : tbit;
      tsh <= tsh_n;
      tx <= tx_n;
    end
  state_t rs, rs_n;
  logic [W-1:0] rcnt;
  logic [2:0] rbit;
  logic [7:0] rsh, rxd;
  logic r1, r2, r3, fall, rend, rhalf;
  logic rx_ready, overrun, frame_err, rx_irq_en;
  logic stop_ok, stop_bad, rx_ready_n, overrun_n, frame_err_n, irq_en_n;
  assign fall = r3 & ~r2;
  assign rend = rcnt == LAST;
  assign rhalf = rcnt == HALF;
  always_ff @(posedge clk)
    if (reset) rs <= IDLE;
    else rs <= rs_n;
  always_comb begin
    rs_n = rs;
    case (rs)
      IDLE:    rs_n = fall ? START : IDLE;
      START:   rs_n = rhalf ? (r2 ? IDLE : DATA) : START;
      DATA:    rs_n = (rend && rbit == 3'd7) ? STOP : DATA;
      default: rs_n = rend ? IDLE : STOP;
    endcase
  end
  // a completing byte wins over a same-edge RXD read; the read still suppresses overrun
  always_comb begin
    stop_ok = rs == STOP && rend && r2;
    stop_bad = rs == STOP && rend && !r2;
    rx_ready_n = stop_ok ? 1'b1 : rd_rxd ? 1'b0 : rx_ready;
    overrun_n = stop_ok ? ~rd_rxd & (overrun | rx_ready) : rd_rxd ? 1'b0 : overrun;
    frame_err_n = stop_bad ? 1'b1 : rd_rxd ? 1'b0 : frame_err;
    irq_en_n = wr_con ? WriteData[2] : rx_irq_en;
  end
  always_ff @(posedge clk)
    if (reset) begin
      {r1, r2, r3} <= 3'b111;
      rcnt <= '0;
      rbit <= '0;
      rsh <= '0;
      rxd <= '0;
      rx_ready <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
      rx_irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      {r1, r2, r3} <= {rx, r1, r2};
      rcnt <= (rs == IDLE || rs_n != rs || rend) ? '0 : rcnt + 1'b1;
      rbit <= rs != DATA ? 3'd0 : rend ? rbit + 1'b1 : rbit;
      rsh <= (rs == DATA && rend) ? {r2, rsh[7:1]} : rsh;
      rxd <= stop_ok ? rsh : rxd;
      rx_ready <= rx_ready_n;
      overrun <= overrun_n;
      frame_err <= frame_err_n;
      rx_irq_en <= irq_en_n;
      irq <= rx_ready_n & irq_en_n;
    end
  assign ReadData = !MemRd ? 32'd0 : sel_rxd ? {24'd0, rxd} :
                    sel_con ? {27'd0, frame_err, overrun, rx_irq_en, tx_busy, rx_ready} : 32'd0;
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: table-driven register checks plus scoreboarded tx/rx frame sequences for uart_mmio
module tb_uart_mmio;
  localparam int CPB = 16;
  localparam logic [31:0] TXD = 32'h40000018, RXD = 32'h4000001C, CON = 32'h40000020;
  logic clk = 0, reset = 1, MemRd = 0, MemWr = 0, rx = 1;
  logic [31:0] Addr = 0, WriteData = 0, ReadData;
  logic tx, irq;
  int n_chk = 0, n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_rxd = 8'h00;
  bit mon_go = 0, mon_en = 1;
  int d;
  logic [31:0] v;
  logic [9:0] fr;
  typedef struct {
    bit rd;
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[18];

  always #5 clk = ~clk;

  uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .rx(rx), .tx(tx), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] dat);
    MemWr = 1; Addr = a; WriteData = dat;
    @(negedge clk);
    MemWr = 0; Addr = 0; WriteData = 0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] dat);
    MemRd = 1; Addr = a;
    #1 dat = ReadData;
    @(negedge clk);
    MemRd = 0; Addr = 0;
  endtask

  task automatic con_chk(input string name, input logic [31:0] exp);
    logic [31:0] r;
    bus_rd(CON, r);
    check(name, r, exp);
  endtask

  task automatic rxd_chk(input string name);
    logic [31:0] r;
    bus_rd(RXD, r);
    while (rx_q.size() > 0) last_rxd = rx_q.pop_front();
    check(name, r, {24'd0, last_rxd});
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1;
  endtask

  task automatic tx_drain();
    for (int i = 0; i < 400 && tx_q.size() != 0; i++) @(negedge clk);
    check("tx_drain", 32'(tx_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic s0, s9;
    bit en;
    wait (mon_go);
    forever begin
      @(negedge tx);
      en = mon_en;
      repeat (CPB / 2) @(negedge clk);
      s0 = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      s9 = tx;
      if (en) begin
        check("tx_start_bit", {31'd0, s0}, 32'd0);
        check("tx_stop_bit", {31'd0, s9}, 32'd1);
        if (tx_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL tx_unexpected: got %h expected no frame", b);
        end else check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    vt = '{
      '{1, 0, TXD, 32'h0, 32'h0},
      '{1, 0, RXD, 32'h0, 32'h0},
      '{1, 0, CON, 32'h0, 32'h0},
      '{0, 1, CON, 32'h4, 32'h0},
      '{1, 0, CON, 32'h0, 32'h4},
      '{1, 0, CON + 1, 32'h0, 32'h0},
      '{1, 0, 32'h40000024, 32'h0, 32'h0},
      '{0, 0, CON, 32'h0, 32'h0},
      '{0, 1, CON + 1, 32'h0, 32'h0},
      '{1, 0, CON, 32'h0, 32'h4},
      '{0, 1, CON, 32'hFFFFFFFB, 32'h0},
      '{1, 0, CON, 32'h0, 32'h0},
      '{0, 1, TXD + 2, 32'hA5, 32'h0},
      '{1, 0, CON, 32'h0, 32'h0},
      '{0, 1, CON, 32'h4, 32'h0},
      '{1, 0, CON, 32'h0, 32'h4},
      '{0, 1, RXD, 32'hFF, 32'h0},
      '{1, 0, RXD, 32'h0, 32'h0}
    };
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 0;
    mon_go = 1;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      if (vt[i].wr) bus_wr(vt[i].addr, vt[i].data);
      else if (vt[i].rd) begin
        bus_rd(vt[i].addr, v);
        check($sformatf("reg_vec%0d", i), v, vt[i].exp);
      end else begin
        Addr = vt[i].addr;
        #1 check($sformatf("reg_vec%0d", i), ReadData, vt[i].exp);
        @(negedge clk);
        Addr = 0;
      end
    end

    fr = {1'b1, 8'hA5, 1'b0};
    tx_q.push_back(8'hA5);
    bus_wr(TXD, 32'hA5);
    MemRd = 1; Addr = CON;
    for (int i = 0; i < 160; i++) begin
      #1;
      check($sformatf("tx_bit_c%0d", i), {31'd0, tx}, {31'd0, fr[i / 16]});
      check($sformatf("tx_busy_c%0d", i), ReadData, 32'h6);
      @(negedge clk);
    end
    #1;
    check("tx_idle_after_stop", {31'd0, tx}, 32'd1);
    check("tx_busy_cleared", ReadData, 32'h4);
    MemRd = 0; Addr = 0;
    tx_drain();

    tx_q.push_back(8'h11);
    bus_wr(TXD, 32'h11);
    repeat (19) @(negedge clk);
    bus_wr(TXD, 32'h22);
    repeat (139) @(negedge clk);
    bus_wr(TXD, 32'h44);
    tx_q.push_back(8'h33);
    bus_wr(TXD, 32'h33);
    check("tx_accept_c161", {31'd0, tx}, 32'd0);
    con_chk("tx_busy_c161", 32'h6);
    tx_drain();

    send_rx(8'h3C, 1);
    check("irq_set", {31'd0, irq}, 32'd1);
    con_chk("con_ready", 32'h5);
    rxd_chk("rxd_3c");
    check("irq_clear", {31'd0, irq}, 32'd0);
    con_chk("con_after_read", 32'h4);

    send_rx(8'h81, 1);
    send_rx(8'h7E, 1);
    con_chk("con_overrun", 32'hD);
    bus_wr(CON, 32'h0);
    check("irq_masked", {31'd0, irq}, 32'd0);
    con_chk("con_masked", 32'h9);
    bus_wr(CON, 32'h4);
    check("irq_unmasked", {31'd0, irq}, 32'd1);
    rxd_chk("rxd_overrun");
    con_chk("con_overrun_cleared", 32'h4);

    fork
      send_rx(8'h5A, 1);
      begin
        MemRd = 1; Addr = CON;
        for (d = 0; d < 200; d++) begin
          #1;
          if (ReadData[0]) break;
          @(negedge clk);
        end
        MemRd = 0; Addr = 0;
      end
    join
    check("rx_latency_window", {31'd0, d >= 150 && d <= 160}, 32'd1);
    fork
      send_rx(8'hC3, 1);
      begin
        repeat (d - 1) @(negedge clk);
        MemRd = 1; Addr = RXD;
        #1 v = ReadData;
        @(negedge clk);
        MemRd = 0; Addr = 0;
      end
    join
    check("race_read_old", v, 32'h5A);
    con_chk("race_con", 32'h5);
    rxd_chk("race_rxd_new");
    con_chk("race_con_cleared", 32'h4);

    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    repeat (40) @(negedge clk);
    con_chk("glitch_con", 32'h4);
    rxd_chk("glitch_rxd");
    send_rx(8'h99, 0);
    con_chk("frame_err_con", 32'h14);
    check("frame_err_irq", {31'd0, irq}, 32'd0);
    rxd_chk("frame_err_rxd");
    con_chk("frame_err_cleared", 32'h4);

    tx_drain();
    mon_en = 0;
    bus_wr(TXD, 32'h55);
    repeat (49) @(negedge clk);
    reset = 1;
    @(negedge clk);
    MemRd = 1; Addr = CON;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_con", ReadData, 32'h0);
    MemRd = 0; Addr = 0;
    reset = 0;
    @(negedge clk);
    bus_wr(TXD, 32'h0F);
    check("post_rst_tx", {31'd0, tx}, 32'd0);
    con_chk("post_rst_con", 32'h2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
